// File: rtl/router_pkt_tx.sv
// Packet transmitter: buffers host bytes, then sends a header beat plus payload beats to the router.
// Optional ROUTER_TX_TIMEOUT_EN aborts WAIT_RDY after TIMEOUT_CYCLES cycles with a tx_err pulse.
module router_pkt_tx #(
  parameter int DEPTH          = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     host_wr_en,
  input  logic [7:0]               host_wr_data,
  output logic [$clog2(DEPTH):0]   host_count,
  output logic                     host_full,
  input  logic                     send,
  input  logic [1:0]               send_dest,
  input  logic [1:0]               send_type,
  output logic                     busy,
  output logic                     tx_done,
  output logic                     tx_err,
  output logic                     valid,
  output logic [1:0]               dest_addr,
  output logic [1:0]               packet_type,
  output logic [7:0]               payload,
  output logic                     eop,
  input  logic                     ready
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, HEADER, DATA, WAIT_RDY} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [CW-1:0]   len_q, len_d;
  logic [CW-1:0]   rd_idx_q, rd_idx_d;
  logic [1:0]      dest_lat_q, dest_lat_d;
  logic [1:0]      type_lat_q, type_lat_d;
  logic            valid_q, valid_d;
  logic            eop_q, eop_d;
  logic [7:0]      payload_q, payload_d;
  logic [1:0]      dest_addr_q, dest_addr_d;
  logic [1:0]      packet_type_q, packet_type_d;
  logic            tx_done_q, tx_done_d;
  logic [7:0]      buf_q [DEPTH];
  logic [7:0]      buf_d [DEPTH];
  logic            full_w;

`ifdef ROUTER_TX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0]   to_q, to_d;
  logic            tx_err_q, tx_err_d;
`endif

  assign full_w = (count_q == CW'(DEPTH));

  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    len_d         = len_q;
    rd_idx_d      = rd_idx_q;
    dest_lat_d    = dest_lat_q;
    type_lat_d    = type_lat_q;
    valid_d       = 1'b0;
    eop_d         = 1'b0;
    payload_d     = 8'h00;
    dest_addr_d   = 2'b00;
    packet_type_d = 2'b00;
    tx_done_d     = 1'b0;
    buf_d         = buf_q;
`ifdef ROUTER_TX_TIMEOUT_EN
    to_d          = to_q;
    tx_err_d      = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        // A valid send takes priority over a same-cycle host write.
        if (send && (count_q != '0)) begin
          state_d       = HEADER;
          len_d         = count_q;
          dest_lat_d    = send_dest;
          type_lat_d    = send_type;
          valid_d       = 1'b1;
          payload_d     = 8'(count_q);
          dest_addr_d   = send_dest;
          packet_type_d = send_type;
        end else if (host_wr_en && !full_w) begin
          buf_d[count_q[AW-1:0]] = host_wr_data;
          count_d                = count_q + CW'(1);
        end
      end
      HEADER: begin
        state_d       = DATA;
        valid_d       = 1'b1;
        payload_d     = buf_q[0];
        eop_d         = (len_q == CW'(1));
        rd_idx_d      = CW'(1);
        dest_addr_d   = dest_lat_q;
        packet_type_d = type_lat_q;
      end
      DATA: begin
        if (rd_idx_q == len_q) begin
          state_d = WAIT_RDY;
`ifdef ROUTER_TX_TIMEOUT_EN
          to_d    = '0;
`endif
        end else begin
          valid_d       = 1'b1;
          payload_d     = buf_q[rd_idx_q[AW-1:0]];
          eop_d         = ((rd_idx_q + CW'(1)) == len_q);
          rd_idx_d      = rd_idx_q + CW'(1);
          dest_addr_d   = dest_lat_q;
          packet_type_d = type_lat_q;
        end
      end
      WAIT_RDY: begin
        if (ready) begin
          tx_done_d = 1'b1;
          state_d   = IDLE;
          count_d   = '0;
          rd_idx_d  = '0;
`ifdef ROUTER_TX_TIMEOUT_EN
        end else if (to_q == TW'(TIMEOUT_CYCLES - 1)) begin
          tx_err_d  = 1'b1;
          state_d   = IDLE;
          count_d   = '0;
          rd_idx_d  = '0;
        end else begin
          to_d      = to_q + TW'(1);
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      count_q       <= '0;
      len_q         <= '0;
      rd_idx_q      <= '0;
      dest_lat_q    <= 2'b00;
      type_lat_q    <= 2'b00;
      valid_q       <= 1'b0;
      eop_q         <= 1'b0;
      payload_q     <= 8'h00;
      dest_addr_q   <= 2'b00;
      packet_type_q <= 2'b00;
      tx_done_q     <= 1'b0;
`ifdef ROUTER_TX_TIMEOUT_EN
      to_q          <= '0;
      tx_err_q      <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      len_q         <= len_d;
      rd_idx_q      <= rd_idx_d;
      dest_lat_q    <= dest_lat_d;
      type_lat_q    <= type_lat_d;
      valid_q       <= valid_d;
      eop_q         <= eop_d;
      payload_q     <= payload_d;
      dest_addr_q   <= dest_addr_d;
      packet_type_q <= packet_type_d;
      tx_done_q     <= tx_done_d;
`ifdef ROUTER_TX_TIMEOUT_EN
      to_q          <= to_d;
      tx_err_q      <= tx_err_d;
`endif
    end
  end

  // Payload storage holds no control meaning, so it is left out of reset.
  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

  assign host_count  = count_q;
  assign host_full   = full_w;
  assign busy        = (state_q != IDLE);
  assign tx_done     = tx_done_q;
  assign valid       = valid_q;
  assign eop         = eop_q;
  assign payload     = payload_q;
  assign dest_addr   = dest_addr_q;
  assign packet_type = packet_type_q;

`ifdef ROUTER_TX_TIMEOUT_EN
  assign tx_err = tx_err_q;
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign tx_err = 1'b0;
`endif

endmodule
